// File: rtl/df_rate_sequencer_pkg.sv
// Shared definitions for the decimating-filter rate sequencer: state encodings,
// bypass bit positions, config-word layout and the config validity rule.
package df_rate_sequencer_pkg;

    localparam int unsigned BYPASS_W = 4;
    localparam int unsigned DEC_W    = 15;
    localparam int unsigned SHIFT_W  = 6;

    localparam int unsigned BYP_HB0 = 0;
    localparam int unsigned BYP_CIC = 1;
    localparam int unsigned BYP_HB1 = 2;
    localparam int unsigned BYP_FIR = 3;

    typedef enum logic [1:0] {
        DFSEQ_FLUSH  = 2'd0,
        DFSEQ_SETTLE = 2'd1,
        DFSEQ_RUN    = 2'd2
    } dfseq_state_t;

    typedef struct packed {
        logic [BYPASS_W-1:0] bypass;
        logic [DEC_W-1:0]    decimation;
        logic [SHIFT_W-1:0]  shift;
    } dfseq_cfg_t;

    localparam dfseq_cfg_t DFSEQ_CFG_DEFAULT = '{bypass: 4'b1111, decimation: 15'd2, shift: 6'd0};

    // An active CIC cannot decimate by less than 2.
    function automatic logic cfg_is_valid(input dfseq_cfg_t c);
        return c.bypass[BYP_CIC] || (c.decimation >= DEC_W'(2));
    endfunction

endpackage

// File: rtl/df_rate_sequencer_cfg_holding.sv
// One-deep pending config register with validity check; the latest accepted
// request while a sequence is in progress replaces any earlier one.
module df_cfg_holding
    import df_rate_sequencer_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       i_wr,
    input  dfseq_cfg_t i_cfg,
    input  logic       i_store,
    input  logic       i_clear,
    output logic       o_pendingValid,
    output dfseq_cfg_t o_pendingCfg,
    output logic       o_reject,
    output logic       o_accept
);

    logic       w_valid;
    logic       r_pendingValid;
    dfseq_cfg_t r_pendingCfg;

    assign w_valid  = cfg_is_valid(i_cfg);
    assign o_reject = i_wr & ~w_valid;
    assign o_accept = i_wr & w_valid;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_pendingValid <= 1'b0;
            r_pendingCfg   <= DFSEQ_CFG_DEFAULT;
        end else if (i_clear) begin
            r_pendingValid <= 1'b0;
        end else if (o_accept && i_store) begin
            r_pendingValid <= 1'b1;
            r_pendingCfg   <= i_cfg;
        end
    end

    assign o_pendingValid = r_pendingValid;
    assign o_pendingCfg   = r_pendingCfg;

endmodule

// File: rtl/df_rate_sequencer.sv
// Rate-change sequencer for the decimating filter chain: applies a new config
// atomically, flushes the chain under reset, then mutes until output settles.
module df_rate_sequencer
    import df_rate_sequencer_pkg::*;
#(
    parameter int unsigned FlushCycles   = 64,
    parameter int unsigned SettleSamples = 32,
    parameter int unsigned TimeoutCycles = 65535
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cfgWr,
    input  logic [BYPASS_W-1:0] cfgBypass,
    input  logic [DEC_W-1:0]    cfgDecimation,
    input  logic [SHIFT_W-1:0]  cfgShift,
    input  logic                dfClkEnOut,
    output logic [BYPASS_W-1:0] bypassOut,
    output logic [DEC_W-1:0]    cicDecimationOut,
    output logic [SHIFT_W-1:0]  cicShiftOut,
    output logic                dfReset,
    output logic                mute,
    output logic                busy,
    output logic                cfgErr,
    output logic                timeoutErr
);

    localparam int unsigned FLUSH_W = $clog2(FlushCycles + 1);
    localparam int unsigned SET_W   = $clog2(SettleSamples + 1);
    localparam int unsigned TO_W    = 16;

    dfseq_state_t     r_state;
    dfseq_cfg_t       r_cfg;
    logic             r_dfReset;
    logic             r_mute;
    logic             r_busy;
    logic             r_cfgErr;
    logic             r_timeoutErr;
    logic [FLUSH_W-1:0] r_flushCnt;
    logic [SET_W-1:0]   r_strobeCnt;
    logic [TO_W-1:0]    r_toCnt;

    dfseq_cfg_t       w_reqCfg;
    dfseq_cfg_t       w_pendingCfg;
    dfseq_cfg_t       w_nextCfg;
    logic             w_pendingValid;
    logic             w_reject;
    logic             w_accept;
    logic             w_store;
    logic [SET_W:0]   w_strobeSum;
    logic             w_settleDone;
    logic             w_timeout;
    logic             w_reflush;
    logic             w_enterFlush;

    assign w_reqCfg = {cfgBypass, cfgDecimation, cfgShift};
    assign w_store  = (r_state != DFSEQ_RUN);

    df_cfg_holding u_hold (
        .clk            (clk),
        .reset          (reset),
        .i_wr           (cfgWr),
        .i_cfg          (w_reqCfg),
        .i_store        (w_store),
        .i_clear        (w_reflush),
        .o_pendingValid (w_pendingValid),
        .o_pendingCfg   (w_pendingCfg),
        .o_reject       (w_reject),
        .o_accept       (w_accept)
    );

    // A strobe completing the count wins over a timeout in the same cycle.
    always_comb begin
        w_strobeSum  = {1'b0, r_strobeCnt} + (SET_W+1)'(dfClkEnOut);
        w_settleDone = (r_state == DFSEQ_SETTLE) && (w_strobeSum >= (SET_W+1)'(SettleSamples));
        w_timeout    = (r_state == DFSEQ_SETTLE) && !w_settleDone
                       && (r_toCnt == TO_W'(TimeoutCycles - 1));
        w_reflush    = (w_settleDone || w_timeout) && (w_pendingValid || w_accept);
        w_enterFlush = w_reflush || ((r_state == DFSEQ_RUN) && w_accept);
        w_nextCfg    = w_accept ? w_reqCfg : w_pendingCfg;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state      <= DFSEQ_FLUSH;
            r_cfg        <= DFSEQ_CFG_DEFAULT;
            r_dfReset    <= 1'b1;
            r_mute       <= 1'b1;
            r_busy       <= 1'b1;
            r_cfgErr     <= 1'b0;
            r_timeoutErr <= 1'b0;
            r_flushCnt   <= '0;
            r_strobeCnt  <= '0;
            r_toCnt      <= '0;
        end else begin
            if (w_reject) begin
                r_cfgErr <= 1'b1;
            end else if (w_accept) begin
                r_cfgErr <= 1'b0;
            end

            if (w_enterFlush) begin
                r_state      <= DFSEQ_FLUSH;
                r_cfg        <= w_nextCfg;
                r_dfReset    <= 1'b1;
                r_mute       <= 1'b1;
                r_busy       <= 1'b1;
                r_timeoutErr <= 1'b0;
                r_flushCnt   <= '0;
                r_strobeCnt  <= '0;
                r_toCnt      <= '0;
            end else begin
                case (r_state)
                    DFSEQ_FLUSH: begin
                        if (r_flushCnt == FLUSH_W'(FlushCycles - 1)) begin
                            r_state     <= DFSEQ_SETTLE;
                            r_dfReset   <= 1'b0;
                            r_strobeCnt <= '0;
                            r_toCnt     <= '0;
                        end else if (r_flushCnt != '1) begin
                            r_flushCnt <= r_flushCnt + 1'b1;
                        end
                    end
                    DFSEQ_SETTLE: begin
                        if (w_settleDone || w_timeout) begin
                            r_state <= DFSEQ_RUN;
                            r_mute  <= 1'b0;
                            r_busy  <= 1'b0;
                            if (w_timeout) begin
                                r_timeoutErr <= 1'b1;
                            end
                        end else begin
                            r_strobeCnt <= w_strobeSum[SET_W-1:0];
                            if (r_toCnt != '1) begin
                                r_toCnt <= r_toCnt + 1'b1;
                            end
                        end
                    end
                    DFSEQ_RUN: begin
                        r_dfReset <= 1'b0;
                        r_mute    <= 1'b0;
                        r_busy    <= 1'b0;
                    end
                    default: begin
                        r_state <= DFSEQ_FLUSH;
                    end
                endcase
            end
        end
    end

    assign bypassOut        = r_cfg.bypass;
    assign cicDecimationOut = r_cfg.decimation;
    assign cicShiftOut      = r_cfg.shift;
    assign dfReset          = r_dfReset;
    assign mute             = r_mute;
    assign busy             = r_busy;
    assign cfgErr           = r_cfgErr;
    assign timeoutErr       = r_timeoutErr;

endmodule

// File: doc/df_rate_sequencer.md
Name: df_rate_sequencer

Overview:
- Sequences reconfiguration of the channel decimating filter chain (HB0, CIC, CIC comp, HB1, video FIR). It accepts a new rate configuration and applies the stage bypass bits, CIC decimation and CIC gain shift atomically.
- On each change it flushes the chain by holding the filter-chain reset, then mutes downstream consumers until a programmed number of output samples has emerged.
- Sits between the channel register block and the decimating filter, and owns the filter's config and reset inputs.

Parameters:
- FlushCycles, 64, clocks the chain reset is held high per reconfiguration (>=2).
- SettleSamples, 32, output sample strobes counted before unmuting (>=1).
- TimeoutCycles, 65535, max clocks waiting in SETTLE for strobes before forcing RUN.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-low reset.
- cfgWr  in  1  one-clock strobe: load cfgBypass/cfgDecimation/cfgShift.
- cfgBypass  in  4  requested {bypassFir, bypassHb1, bypassCic, bypassHb0}.
- cfgDecimation  in  15  requested CIC decimation.
- cfgShift  in  6  requested CIC gain shift.
- dfClkEnOut  in  1  output sample strobe from the decimating filter.
- bypassOut  out  4  applied bypass bits to the filter.
- cicDecimationOut  out  15  applied CIC decimation.
- cicShiftOut  out  6  applied CIC shift.
- dfReset  out  1  active-high filter-chain reset.
- mute  out  1  high = downstream must ignore filter output.
- busy  out  1  high in any state except RUN.
- cfgErr  out  1  sticky: rejected config; cleared by the next accepted cfgWr.
- timeoutErr  out  1  sticky: SETTLE timed out; cleared on entry to FLUSH.

Behaviour:
- States are FLUSH, SETTLE and RUN. All outputs are registered.
- Reset (reset==0 at a clk edge):
  - state=FLUSH, bypassOut=4'b1111, cicDecimationOut=2, cicShiftOut=0.
  - dfReset=1, mute=1, busy=1, cfgErr=0, timeoutErr=0.
  - flush counter=0, pending=0.
  - Reset mid-sequence abandons the sequence and any pending request.
- Validation:
  - A cfgWr with cfgBypass[1]==0 and cfgDecimation<2 is rejected: cfgErr<=1 next clock, no state or pending change.
  - Any other cfgWr is accepted and clears cfgErr.
- RUN:
  - dfReset=0, mute=0, busy=0.
  - Accepted cfgWr at edge N: at edge N+1 the config outputs take the new values, state=FLUSH, dfReset=1, mute=1, busy=1, timeoutErr=0.
- FLUSH:
  - dfReset high for exactly FlushCycles clocks, then state=SETTLE and dfReset=0 on the following edge.
  - Strobe counter cleared on entry; dfClkEnOut is ignored in FLUSH.
- SETTLE:
  - Counts dfClkEnOut pulses. When the count reaches SettleSamples, state=RUN next edge, so mute falls one clock after the SettleSamples-th strobe.
  - Cycle counter: when TimeoutCycles clocks elapse with the strobe count still short, timeoutErr<=1 and state=RUN.
  - A strobe and the timeout in the same cycle that completes the count go to RUN without timeoutErr.
- Request during FLUSH/SETTLE:
  - Accepted cfgWr is stored in a one-deep pending register; latest wins.
  - Config outputs are unchanged until the pending request is applied.
  - Where the sequence would enter RUN, it instead enters FLUSH with the pending config applied (mute stays high, no RUN cycle), and pending clears.
  - cfgWr in the same cycle as that transition: it becomes the applied config (it overrides pending), with no extra flush.
- Widths and counters:
  - Flush counter is clog2(FlushCycles+1) bits, strobe counter clog2(SettleSamples+1) bits, timeout counter 16 bits.
  - Counters saturate, never wrap.
- Config outputs never change except on a FLUSH entry edge. The filter therefore never sees a config change while out of reset.

Decomposition:
- Shared package (channel defs include): state encodings DFSEQ_FLUSH/DFSEQ_SETTLE/DFSEQ_RUN, bypass bit index constants, config-word field widths (4/15/6).
- One natural sub-module: df_cfg_holding — the pending register plus validity check, outputting pendingValid, pendingCfg and reject.
- The FSM and counters stay in the top.

Test Plan:
- Reset release, FlushCycles=64, dfClkEnOut every 8 clocks:
  - dfReset high 64 clocks after release, config = 1111/2/0.
  - mute falls one clock after the 32nd strobe; busy=0.
- In RUN, cfgWr with bypass=0000, dec=100, shift=20:
  - next edge: outputs update, dfReset=1 for 64 clocks.
  - after 32 strobes, mute=0.
- cfgWr with bypass=0000, dec=1 in RUN:
  - cfgErr=1 next clock, state stays RUN, outputs unchanged.
  - a following valid cfgWr clears cfgErr.
- Two cfgWr (dec=50 then dec=200) during SETTLE:
  - at settle completion, direct re-entry to FLUSH with dec=200, mute never drops.
  - dec=50 is never applied.
- No dfClkEnOut after flush, TimeoutCycles=1000:
  - RUN after 1000 SETTLE clocks, timeoutErr=1.
  - the next accepted cfgWr clears it at FLUSH entry.
- reset low for one clock in mid-SETTLE with pending set:
  - returns to the reset values, pending is discarded.
  - the default config is applied after the flush.
